// File: rtl/fp_div_32.sv
// Single-precision IEEE-754 divider: restoring radix-2, one quotient bit per cycle,
// fixed 31-cycle latency for every operand class. Subnormals in are zero, flushed out.
module fp_div_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  r_mode_i,
  input  logic [31:0] fp_x_i,
  input  logic [31:0] fp_y_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] fp_z_o,
  output logic        ovrf_o,
  output logic        udrf_o
);

  typedef enum logic [2:0] {StIdle, StUnpack, StDivide, StNorm, StRound} state_e;

  state_e             state_q, state_d;
  logic [31:0]        x_q, y_q;
  logic [2:0]         rm_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [25:0]        rem_q;
  logic [23:0]        dvs_q;
  logic [27:0]        quo_q;
  logic [4:0]         cnt_q;
  logic               sticky_q;
  logic               spec_q;
  logic [31:0]        spec_z_q;
  logic [31:0]        z_q, z_d;
  logic               ovrf_q, ovrf_d, udrf_q, udrf_d;
  logic               done_q;

  // Unpack / special-case classification
  logic               x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, sign_u;
  logic signed [9:0]  exp_u;
  logic               spec_u;
  logic [31:0]        spec_z_u;

  always_comb begin
    x_nan  = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
    y_nan  = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
    x_inf  = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
    y_inf  = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
    x_zero = (x_q[30:23] == 8'h00);
    y_zero = (y_q[30:23] == 8'h00);
    sign_u = x_q[31] ^ y_q[31];
    exp_u  = $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;
    spec_u   = 1'b1;
    spec_z_u = 32'h7FC0_0000;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      spec_z_u = 32'h7FC0_0000;
    end else if (x_inf || y_zero) begin
      spec_z_u = {sign_u, 8'hFF, 23'd0};
    end else if (x_zero || y_inf) begin
      spec_z_u = {sign_u, 31'd0};
    end else begin
      spec_u = 1'b0;
    end
  end

  // One restoring step
  logic        rem_ge;
  logic [25:0] rem_nxt;

  always_comb begin
    rem_ge  = (rem_q >= {2'b00, dvs_q});
    rem_nxt = rem_ge ? (rem_q - {2'b00, dvs_q}) : rem_q;
  end

  // Rounding and exponent range handling
  logic [23:0]       mant, mant_f;
  logic [24:0]       mant_r;
  logic              guard, stk, inc;
  logic signed [9:0] e_r;

  always_comb begin
    mant  = quo_q[27:4];
    guard = quo_q[3];
    stk   = sticky_q | (|quo_q[2:0]);
    case (rm_q)
      3'd0:    inc = guard & (stk | mant[0]);
      3'd2:    inc = sign_q & (guard | stk);
      3'd3:    inc = ~sign_q & (guard | stk);
      3'd4:    inc = guard;
      default: inc = 1'b0;
    endcase
    mant_r = {1'b0, mant} + {24'd0, inc};
    mant_f = mant_r[23:0];
    e_r    = exp_q;
    if (mant_r[24]) begin
      mant_f = mant_r[24:1];
      e_r    = exp_q + 10'sd1;
    end
    ovrf_d = 1'b0;
    udrf_d = 1'b0;
    z_d    = {sign_q, e_r[7:0], mant_f[22:0]};
    if (spec_q) begin
      z_d = spec_z_q;
    end else if (e_r >= 10'sd255) begin
      ovrf_d = 1'b1;
      case (rm_q)
        3'd1:    z_d = {sign_q, 31'h7F7F_FFFF};
        3'd2:    z_d = sign_q ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        3'd3:    z_d = sign_q ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default: z_d = {sign_q, 8'hFF, 23'd0};
      endcase
    end else if (e_r <= 10'sd0) begin
      udrf_d = 1'b1;
      z_d    = {sign_q, 31'd0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StUnpack;
      StUnpack: state_d = StDivide;
      StDivide: if (cnt_q == 5'd27) state_d = StNorm;
      StNorm:   state_d = StRound;
      StRound:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = done_q;
    fp_z_o = z_q;
    ovrf_o = ovrf_q;
    udrf_o = udrf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      rm_q     <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      spec_q   <= 1'b0;
      spec_z_q <= '0;
      z_q      <= '0;
      ovrf_q   <= 1'b0;
      udrf_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == StRound);
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            x_q  <= fp_x_i;
            y_q  <= fp_y_i;
            rm_q <= (r_mode_i > 3'd4) ? 3'd0 : r_mode_i;
          end
        end
        StUnpack: begin
          sign_q   <= sign_u;
          exp_q    <= exp_u;
          rem_q    <= {3'b001, x_q[22:0]};
          dvs_q    <= {1'b1, y_q[22:0]};
          quo_q    <= '0;
          cnt_q    <= '0;
          spec_q   <= spec_u;
          spec_z_q <= spec_z_u;
        end
        StDivide: begin
          rem_q <= {rem_nxt[24:0], 1'b0};
          quo_q <= {quo_q[26:0], rem_ge};
          cnt_q <= cnt_q + 5'd1;
        end
        StNorm: begin
          sticky_q <= |rem_q;
          if (!quo_q[27]) begin
            quo_q <= {quo_q[26:0], 1'b0};
            exp_q <= exp_q - 10'sd1;
          end
        end
        StRound: begin
          z_q    <= z_d;
          ovrf_q <= ovrf_d;
          udrf_q <= udrf_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_32.sv
// Self-checking bench for fp_div_32: directed vectors, randomized operands against an
// exact-arithmetic reference, start/reset protocol and back-to-back timing.
module tb_fp_div_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  r_mode = '0;
  logic [31:0] fp_x = '0, fp_y = '0;
  logic        busy, done, ovrf, udrf;
  logic [31:0] fp_z;

  int n_checks = 0;
  int n_fail = 0;

  fp_div_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .r_mode_i (r_mode),
    .fp_x_i   (fp_x),
    .fp_y_i   (fp_y),
    .busy_o   (busy),
    .done_o   (done),
    .fp_z_o   (fp_z),
    .ovrf_o   (ovrf),
    .udrf_o   (udrf)
  );

  always #5 clk = ~clk;

  // Reference: exact quotient with wide integers, then IEEE rounding rules.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] rm);
    logic sign, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, g, s, up;
    logic [127:0] num, den, q, r, mant;
    int ex, ey, e, sh, mode;
    sign   = x[31] ^ y[31];
    ex     = int'(x[30:23]);
    ey     = int'(y[30:23]);
    x_nan  = (ex == 255) && (x[22:0] != 0);
    y_nan  = (ey == 255) && (y[22:0] != 0);
    x_inf  = (ex == 255) && (x[22:0] == 0);
    y_inf  = (ey == 255) && (y[22:0] == 0);
    x_zero = (ex == 0);
    y_zero = (ey == 0);
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) return {2'b00, 32'h7FC00000};
    if (x_inf || y_zero) return {2'b00, sign, 8'hFF, 23'd0};
    if (x_zero || y_inf) return {2'b00, sign, 31'd0};
    mode = (rm > 4) ? 0 : int'(rm);
    num  = 128'({1'b1, x[22:0]}) << 60;
    den  = 128'({1'b1, y[22:0]});
    q    = num / den;
    r    = num % den;
    e    = ex - ey + 127;
    if (q >= (128'd1 << 60)) sh = 37;
    else begin
      sh = 36;
      e  = e - 1;
    end
    mant = q >> sh;
    g    = q[sh-1];
    s    = (r != 0) || ((q & ((128'd1 << (sh - 1)) - 1)) != 0);
    case (mode)
      0: up = g && (s || mant[0]);
      2: up = sign && (g || s);
      3: up = !sign && (g || s);
      4: up = g;
      default: up = 1'b0;
    endcase
    if (up) mant = mant + 1;
    if (mant == (128'd1 << 24)) begin
      mant = 128'd1 << 23;
      e    = e + 1;
    end
    if (e >= 255) begin
      case (mode)
        1: return {2'b10, sign, 31'h7F7FFFFF};
        2: return {2'b10, sign ? 32'hFF800000 : 32'h7F7FFFFF};
        3: return {2'b10, sign ? 32'hFF7FFFFF : 32'h7F800000};
        default: return {2'b10, sign, 8'hFF, 23'd0};
      endcase
    end
    if (e <= 0) return {2'b01, sign, 31'd0};
    return {2'b00, sign, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v[30:0] = 31'h7F800000;
      3: v[30:23] = 8'($urandom_range(230, 254));
      4: v[30:23] = 8'($urandom_range(1, 25));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Drive a request and return just after the accepting edge; inputs are then scrambled.
  task automatic op_begin(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    @(negedge clk);
    fp_x = x; fp_y = y; r_mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fp_x = $urandom; fp_y = $urandom; r_mode = 3'($urandom);
  endtask

  // lat = index of the edge (accept edge = 0) whose following negedge shows done; -1 if none.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
      else @(posedge clk);
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                        output int lat);
    op_begin(x, y, m);
    wait_done(lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, fp_z, ovrf, udrf} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b z=%h ov=%b ud=%b, need all 0",
               busy, done, fp_z, ovrf, udrf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b need 0", busy);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vx[12], vy[12], vz[12];
    logic [2:0]  vm[12];
    logic [1:0]  vf[12];
    int lat;
    vx = '{32'h40B00000, 32'h40B00000, 32'h40B00000, 32'h3F800000, 32'h3F800000, 32'h7F000000,
           32'h7F000000, 32'h00800000, 32'h00000000, 32'h3F800000, 32'h7F800000, 32'h40400000};
    vy = '{32'hC0100000, 32'hC0100000, 32'hC0100000, 32'h40400000, 32'h40400000, 32'h3E800000,
           32'h3E800000, 32'h40000000, 32'h00000000, 32'h80000000, 32'h7F800000, 32'h7F800000};
    vm = '{3'd0, 3'd2, 3'd3, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vz = '{32'hC01C71C7, 32'hC01C71C8, 32'hC01C71C7, 32'h3EAAAAAB, 32'h3EAAAAAA, 32'h7F800000,
           32'h7F7FFFFF, 32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h00000000};
    vf = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 12; i++) begin
      run_op(vx[i], vy[i], vm[i], lat);
      n_checks++;
      if (lat !== 31 || fp_z !== vz[i] || {ovrf, udrf} !== vf[i]) begin
        n_fail++;
        $display("FAIL vector_%0d: got z=%h flags=%b lat=%0d, need z=%h flags=%b lat=31",
                 i, fp_z, {ovrf, udrf}, lat, vz[i], vf[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || fp_z !== vz[11]) begin
      n_fail++;
      $display("FAIL done_pulse_hold: got done=%b busy=%b z=%h, need 0 0 %h",
               done, busy, fp_z, vz[11]);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic [2:0]  m;
    logic [33:0] exp_r;
    int lat;
    for (int i = 0; i < 300; i++) begin
      x = rand_fp();
      y = rand_fp();
      m = 3'($urandom_range(0, 7));
      exp_r = model(x, y, m);
      run_op(x, y, m, lat);
      n_checks++;
      if (lat !== 31 || {ovrf, udrf, fp_z} !== exp_r) begin
        n_fail++;
        $display("FAIL random_%0d: x=%h y=%h m=%0d got z=%h ov=%b ud=%b lat=%0d need z=%h ov=%b ud=%b lat=31",
                 i, x, y, m, fp_z, ovrf, udrf, lat, exp_r[31:0], exp_r[33], exp_r[32]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra;
    op_begin(32'h3F800000, 32'h40400000, 3'd0);
    lat = -1;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge clk);
      start = (i == 10);
      if (i == 10) begin
        fp_x = 32'h40B00000; fp_y = 32'hC0100000;
      end
      if (done) lat = i;
      else @(posedge clk);
    end
    n_checks++;
    if (lat !== 31 || fp_z !== 32'h3EAAAAAB) begin
      n_fail++;
      $display("FAIL ignore_start: got z=%h lat=%0d, need z=3eaaaaab lat=31", fp_z, lat);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL no_queued_op: got %0d extra done pulses, need 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int extra;
    op_begin(32'h40B00000, 32'hC0100000, 3'd0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, fp_z, ovrf, udrf} !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b z=%h ov=%b ud=%b, need all 0",
               busy, done, fp_z, ovrf, udrf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL aborted_op: got %0d busy/done cycles after reset, need 0", extra);
    end
    run_op(32'h3F800000, 32'h40400000, 3'd0, lat);
    n_checks++;
    if (lat !== 31 || fp_z !== 32'h3EAAAAAB || {ovrf, udrf} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_op: got z=%h flags=%b lat=%0d, need z=3eaaaaab flags=00 lat=31",
               fp_z, {ovrf, udrf}, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    run_op(32'h3F800000, 32'h40400000, 3'd1, lat);
    n_checks++;
    if (lat !== 31 || fp_z !== 32'h3EAAAAAA) begin
      n_fail++;
      $display("FAIL b2b_first: got z=%h lat=%0d, need z=3eaaaaaa lat=31", fp_z, lat);
    end
    fp_x = 32'h40B00000; fp_y = 32'hC0100000; r_mode = 3'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fp_x = '0; fp_y = '0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b need 1", busy);
    end
    gap = -1;
    for (int i = 1; i < 100 && gap < 0; i++) begin
      @(negedge clk);
      if (done) gap = i;
      else @(posedge clk);
    end
    n_checks++;
    if (gap !== 32 || fp_z !== 32'hC01C71C8) begin
      n_fail++;
      $display("FAIL b2b_second: got z=%h gap=%0d, need z=c01c71c8 gap=32", fp_z, gap);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
